// File: rtl/fp_to_int_converter.sv
// IEEE-754 single-precision to signed integer converter, truncating toward zero.
// Iterative one-bit-per-cycle denormalizing shifter with saturation and inexact flag.
module fp_to_int_converter #(
  parameter int Data_Width = 32,
  parameter int E          = 8,
  parameter int M          = 23,
  parameter int INT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [Data_Width-1:0] fp_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INT_W-1:0]      int_out,
  output logic                  overflow,
  output logic                  inexact
);

  // Handshake: a word transfers on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.

  localparam int BIAS  = 2**(E-1) - 1;
  localparam int CNT_W = $clog2(INT_W + M + 1);
  localparam logic [E:0]        BIAS_E  = (E+1)'(BIAS);
  localparam logic signed [E:0] E_M     = (E+1)'(M);
  localparam logic signed [E:0] E_MAX   = (E+1)'(INT_W - 1);
  localparam logic [INT_W-1:0]  MAX_INT = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0]  MIN_INT = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, next_state;
  logic               sign;
  logic [INT_W:0]     mag, mag_nx;
  logic [CNT_W-1:0]   cnt;
  logic               left;
  logic [INT_W-1:0]   result;
  logic               ovf_r, inx_r;

  logic               in_sign;
  logic [E-1:0]       in_exp;
  logic [M-1:0]       in_frac;
  logic signed [E:0]  in_e, diff;
  logic               is_zero, is_special, underflow, too_big, exact_min;
  logic               start_left, direct_done;
  logic [CNT_W-1:0]   start_n;
  logic [INT_W:0]     full_mag;

  function automatic logic [INT_W-1:0] apply_sign(input logic s, input logic [INT_W-1:0] m);
    return s ? -m : m;
  endfunction

  assign in_sign    = fp_in[Data_Width-1];
  assign in_exp     = fp_in[Data_Width-2 -: E];
  assign in_frac    = fp_in[M-1:0];
  assign in_e       = $signed({1'b0, in_exp}) - $signed(BIAS_E);
  assign is_zero    = (in_exp == '0);
  assign is_special = &in_exp;
  assign underflow  = in_e[E];
  assign too_big    = (in_e >= E_MAX);
  assign exact_min  = in_sign && (in_e == E_MAX) && (in_frac == '0);
  assign start_left = (in_e > E_M);
  assign diff       = start_left ? (in_e - E_M) : (E_M - in_e);
  assign start_n    = CNT_W'(diff);
  assign full_mag   = {{(INT_W-M){1'b0}}, 1'b1, in_frac};
  assign direct_done = is_zero || is_special || underflow || too_big || (start_n == '0);
  assign mag_nx     = left ? {mag[INT_W-1:0], 1'b0} : {1'b0, mag[INT_W:1]};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign int_out   = result;
  assign overflow  = ovf_r;
  assign inexact   = inx_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = direct_done ? DONE : SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign   <= 1'b0;
      mag    <= '0;
      cnt    <= '0;
      left   <= 1'b0;
      result <= '0;
      ovf_r  <= 1'b0;
      inx_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign  <= in_sign;
          mag   <= full_mag;
          cnt   <= start_n;
          left  <= start_left;
          ovf_r <= 1'b0;
          inx_r <= 1'b0;
          if (is_zero) begin
            // Denormals are flushed; any fraction bits are lost.
            mag    <= '0;
            result <= '0;
            inx_r  <= |in_frac;
          end else if (is_special) begin
            ovf_r  <= 1'b1;
            result <= (|in_frac) ? '0 : (in_sign ? MIN_INT : MAX_INT);
          end else if (underflow) begin
            mag    <= '0;
            result <= '0;
            inx_r  <= 1'b1;
          end else if (too_big) begin
            ovf_r  <= !exact_min;
            result <= in_sign ? MIN_INT : MAX_INT;
          end else if (start_n == '0) begin
            result <= apply_sign(in_sign, full_mag[INT_W-1:0]);
          end
        end
        SHIFT: begin
          mag <= mag_nx;
          cnt <= cnt - CNT_W'(1);
          if (!left) inx_r <= inx_r | mag[0];
          if (cnt == CNT_W'(1)) result <= apply_sign(sign, mag_nx[INT_W-1:0]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int_converter.sv
// Directed bench for fp_to_int_converter: hand-computed vectors, specials,
// backpressure in DONE and asynchronous reset during a shift.
module tb_fp_to_int_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic        overflow;
  logic        inexact;

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] exp_q[$];

  fp_to_int_converter dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .fp_in(fp_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .int_out(int_out), .overflow(overflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Latency counts the accept edge as cycle 1, so n shift steps give n+1.
  task automatic convert(input logic [31:0] fp, input logic [31:0] e_int,
                         input logic e_ovf, input logic e_inx, input int e_lat);
    int lat;
    logic [33:0] exp_v;
    exp_q.push_back({e_int, e_ovf, e_inx});
    lat = 0;
    while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    check($sformatf("in_ready %h", fp), in_ready, 1);
    fp_in = fp;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    exp_v = exp_q.pop_front();
    check($sformatf("out_valid %h", fp), out_valid, 1);
    if (e_lat > 0) check($sformatf("latency %h", fp), lat, e_lat);
    check($sformatf("int_out %h", fp), int_out, exp_v[33:2]);
    check($sformatf("overflow %h", fp), overflow, exp_v[1]);
    check($sformatf("inexact %h", fp), inexact, exp_v[0]);
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0; in_valid = 1'b0; fp_in = '0; out_ready = 1'b1;
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst int_out", int_out, 0);
    check("rst overflow", overflow, 0);
    check("rst inexact", inexact, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // fp word, expected int, overflow, inexact, latency (0 = not checked)
    convert(32'h40A80000, 32'h00000005, 0, 1, 22);
    convert(32'hC1A5999A, 32'hFFFFFFEC, 0, 1, 20);
    convert(32'h4B000000, 32'h00800000, 0, 0, 1);
    convert(32'h4E800000, 32'h40000000, 0, 0, 8);
    convert(32'hCF000000, 32'h80000000, 0, 0, 1);
    convert(32'h4F000000, 32'h7FFFFFFF, 1, 0, 1);
    convert(32'h3F000000, 32'h00000000, 0, 1, 1);
    convert(32'h00000000, 32'h00000000, 0, 0, 1);
    convert(32'h00000001, 32'h00000000, 0, 1, 1);
    convert(32'hFF800000, 32'h80000000, 1, 0, 1);
    convert(32'h7FC00000, 32'h00000000, 1, 0, 1);
    convert(32'h80000000, 32'h00000000, 0, 0, 1);
    convert(32'h7F800000, 32'h7FFFFFFF, 1, 0, 1);
    convert(32'h3F800000, 32'h00000001, 0, 0, 24);

    // Backpressure: stall in DONE while new words are offered.
    out_ready = 1'b0;
    convert(32'h4E800000, 32'h40000000, 0, 0, 8);
    for (int i = 0; i < 5; i++) begin
      fp_in = 32'h3F000000 + i;
      in_valid = i[0];
      @(posedge clk); #1;
      check("bp int_out", int_out, 32'h40000000);
      check("bp flags", {overflow, inexact}, 0);
      check("bp in_ready", in_ready, 0);
      check("bp out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", out_valid, 0);
    check("bp release in_ready", in_ready, 1);
    check("bp held int_out", int_out, 32'h40000000);
    convert(32'hC1A5999A, 32'hFFFFFFEC, 0, 1, 20);

    // Asynchronous reset in the middle of a shift sequence.
    held = int_out;
    fp_in = 32'h40A80000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst held before", held, 32'hFFFFFFEC);
    check("midrst in_ready", in_ready, 1);
    check("midrst out_valid", out_valid, 0);
    check("midrst int_out", int_out, 0);
    check("midrst inexact", inexact, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    convert(32'h41A5999A, 32'h00000014, 0, 1, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_to_int_converter.md
Name: fp_to_int_converter

Overview:
- Sequential IEEE-754 single-precision to signed two's-complement integer converter. It performs the unpack/denormalize direction, the inverse of the FP adder's normalize/pack path.
- Used wherever LeNet5 FP results leave the float datapath, e.g. classifier scores into integer compare or argmax logic.
- Valid/ready on both sides, with an iterative one-bit-per-cycle shifter. Rounds toward zero, with saturation and sticky inexact reporting.

Parameters:
- Data_Width, 32, FP word width.
- E, 8, exponent width. Bias = 2**(E-1)-1.
- M, 23, mantissa (fraction) width.
- INT_W, 32, integer result width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fp_in valid.
- in_ready  output  1  converter can accept a word.
- fp_in  input  Data_Width  FP operand {sign, exponent[E-1:0], fraction[M-1:0]}.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- int_out  output  INT_W  signed result, truncated toward zero.
- overflow  output  1  result saturated (|value| too large, Inf, or NaN).
- inexact  output  1  nonzero fraction bits were discarded.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; in_ready=1; out_valid=0; int_out=0; overflow=0; inexact=0. Any in-flight conversion is dropped.
- States are IDLE, SHIFT and DONE.
- IDLE: in_ready=1. On in_valid&in_ready (the accept edge), capture sign s, exponent ex and mag={1,fraction} zero-extended to INT_W+1 bits. Compute e=ex-Bias as a signed E+1-bit value. Clear inexact and overflow, then classify:
  - ex==0 (zero or denormal, flushed): mag=0; inexact=(fraction!=0); go to DONE.
  - ex all ones (Inf/NaN): overflow=1. Inf gives 2^(INT_W-1)-1 if s=0, or -2^(INT_W-1) if s=1. NaN (fraction!=0) gives 0. Go to DONE.
  - e<0: mag=0; inexact=1; go to DONE.
  - e>=INT_W-1: overflow=1 and saturate by sign. Exception: s=1, e==INT_W-1, fraction==0 is exact -2^(INT_W-1) with overflow=0. Go to DONE.
  - Otherwise: shift count n=|e-M|, direction left if e>M, else right. n==0 goes to DONE; otherwise go to SHIFT.
- SHIFT: one 1-bit shift of mag per cycle, then n decrements.
  - Right shifts OR the bit shifted out into inexact.
  - When n reaches 0 on an edge, go to DONE.
- Latency: out_valid is high in the cycle after accept edge + n edges. Range is 1 to M+1 cycles after accept.
- DONE:
  - out_valid=1.
  - int_out = s ? -mag : mag (INT_W bits), except in saturation, NaN, zero and underflow cases, which use their fixed values.
  - int_out, overflow and inexact are registered and held stable while out_valid=1.
  - in_ready=0, and in_valid is ignored.
  - On out_valid&out_ready, go to IDLE. out_valid drops the next cycle and int_out holds its last value.
- One conversion in flight; there is no input/output overlap. Throughput is 1 per n+2 cycles when out_ready=1.
- Negative zero yields 0 with overflow=0.
- All flags belong to the current result only and are never sticky across transactions.

Test Plan:
- 0x40A80000 (5.25) with out_ready=1 → int_out=0x00000005, inexact=1, overflow=0. out_valid rises 22 cycles after accept (n=21).
- 0xC1A5999A (-20.7) → int_out=0xFFFFFFEC (-20), inexact=1. 0x4B000000 (2^23) → 0x00800000, n=0, out_valid the cycle after accept, inexact=0.
- 0x4E800000 (2^30) → 0x40000000, n=7, exact. 0xCF000000 → 0x80000000, overflow=0. 0x4F000000 → 0x7FFFFFFF, overflow=1.
- Specials:
  - 0x3F000000 → 0, inexact=1.
  - 0x00000000 → 0, no flags.
  - 0x00000001 → 0, inexact=1.
  - 0xFF800000 → 0x80000000, overflow=1.
  - 0x7FC00000 → 0, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with a new fp_in. int_out and flags stay stable, in_ready=0 and no new capture occurs. Raise out_ready: the handshake completes, and the next word is accepted from IDLE.
- Assert rst_n low mid-SHIFT (during 0x40A80000) → outputs clear immediately, giving in_ready=1 and out_valid=0. After release, 0x41A5999A converts to 0x00000014 correctly.
